// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first over WIDTH cycles, one full-subtractor cell
// reused every cycle behind a start/busy/done handshake.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;

  logic cell_d;
  logic cell_bout;

  full_subtractor u_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    state_d      = state_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          sr_d     = '0;
          cnt_d    = '0;
          borrow_d = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        sr_d     = {cell_d, sr_q[WIDTH-1:1]};
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish on the edge that consumes the MSB, including that bit.
          diff_d       = {cell_d, sr_q[WIDTH-1:1]};
          borrow_out_d = cell_bout;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: all registers are small and reset asynchronously to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sa_q         <= '0;
      sb_q         <= '0;
      sr_q         <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule
